// File: rtl/ripple_carry_adder_if.sv
// Operand/result bundle for the registered ripple-carry adder.
// master drives operands, slave returns the registered result.
interface ripple_carry_adder_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] Sum;
  logic         Cout;
  logic         Ovf;
  logic         out_valid;

  modport master (
    output in_valid, A, B,
    input  Sum, Cout, Ovf, out_valid
  );

  modport slave (
    input  in_valid, A, B,
    output Sum, Cout, Ovf, out_valid
  );
endinterface

// File: rtl/ripple_carry_adder.sv
// N-bit ripple-carry adder built from 1-bit full-adder cells,
// with registered sum, carry-out and signed overflow.
module ripple_carry_adder_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module ripple_carry_adder #(
  parameter int N = 8
) (
  input logic clk,
  input logic rst,
  ripple_carry_adder_if.slave bus
);
  logic [N:0]   c;
  logic [N-1:0] s;
  logic         ovf;

  assign c[0] = 1'b0;

  for (genvar gi = 0; gi < N; gi++) begin : g_fa
    ripple_carry_adder_fa u_fa (
      .a  (bus.A[gi]),
      .b  (bus.B[gi]),
      .ci (c[gi]),
      .s  (s[gi]),
      .co (c[gi+1])
    );
  end

  // For N=1 the carry into the MSB is c[0], i.e. zero.
  assign ovf = c[N] ^ c[N-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.Sum       <= '0;
      bus.Cout      <= 1'b0;
      bus.Ovf       <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.Sum  <= s;
        bus.Cout <= c[N];
        bus.Ovf  <= ovf;
      end
    end
  end
endmodule

// File: tb/tb_ripple_carry_adder.sv
// Bench for ripple_carry_adder: directed N=8 cases, then
// random traffic on N=1, 8 and 32 against an arithmetic model.
module tb_ripple_carry_adder;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  ripple_carry_adder_if #(.N(1))  b1 ();
  ripple_carry_adder_if #(.N(8))  b8 ();
  ripple_carry_adder_if #(.N(32)) b32 ();

  ripple_carry_adder #(.N(1))  u1  (.clk(clk), .rst(rst), .bus(b1));
  ripple_carry_adder #(.N(8))  u8  (.clk(clk), .rst(rst), .bus(b8));
  ripple_carry_adder #(.N(32)) u32 (.clk(clk), .rst(rst), .bus(b32));

  task automatic chk(string tag, logic [65:0] got, logic [65:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mask(int n);
    logic [64:0] m;
    m = (65'd1 << n) - 65'd1;
    return m[63:0];
  endfunction

  // {ovf, cout, sum} from plain integer addition
  function automatic logic [65:0] ref_add(int n, logic [63:0] a,
                                          logic [63:0] b);
    logic [64:0] full;
    logic [63:0] sm;
    logic        co, ov;
    full = {1'b0, a} + {1'b0, b};
    sm   = full[63:0] & mask(n);
    co   = full[n];
    ov   = (a[n-1] == b[n-1]) && (sm[n-1] != a[n-1]);
    return {ov, co, sm};
  endfunction

  task automatic chk8(string tag, logic [7:0] s, logic co,
                      logic ov, logic v);
    chk({tag, ".sum"}, 66'(b8.Sum), 66'(s));
    chk({tag, ".cout"}, 66'(b8.Cout), 66'(co));
    chk({tag, ".ovf"}, 66'(b8.Ovf), 66'(ov));
    chk({tag, ".ov"}, 66'(b8.out_valid), 66'(v));
  endtask

  task automatic op8(logic [7:0] a, logic [7:0] b);
    b8.in_valid = 1'b1;
    b8.A = a;
    b8.B = b;
  endtask

  logic [7:0]  da [7] = '{8'h0F, 8'hF0, 8'hAA, 8'hFF, 8'h81, 8'h7F, 8'hFF};
  logic [7:0]  db [7] = '{8'h01, 8'h0F, 8'h55, 8'hFF, 8'h81, 8'h01, 8'h01};
  logic [7:0]  ds [7] = '{8'h10, 8'hFF, 8'hFF, 8'hFE, 8'h02, 8'h80, 8'h00};
  logic        dc [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic        dv [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  int          wid [3] = '{1, 8, 32};
  logic [65:0] exp [3];
  logic [65:0] obs [3];
  logic [63:0] ra  [3];
  logic [63:0] rb  [3];
  logic        rv  [3];

  initial begin
    rst = 1'b1;
    b1.in_valid = 1'b0;  b1.A = '0;  b1.B = '0;
    b32.in_valid = 1'b0; b32.A = '0; b32.B = '0;
    op8(8'hFF, 8'hFF);

    for (int i = 0; i < 2; i++) begin
      step();
      chk8("rst", 8'h00, 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b0;
    b8.in_valid = 1'b0;
    step();
    chk8("rst_rel", 8'h00, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 7; i++) begin
      op8(da[i], db[i]);
      step();
      chk8($sformatf("dir%0d", i), ds[i], dc[i], dv[i], 1'b1);
    end

    op8(8'h12, 8'h34);
    step();
    chk8("hold0", 8'h46, 1'b0, 1'b0, 1'b1);
    b8.in_valid = 1'b0;
    b8.A = 8'hFF;
    b8.B = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk8($sformatf("hold%0d", i + 1), 8'h46, 1'b0, 1'b0, 1'b0);
    end

    op8(8'h10, 8'h20);
    step();
    chk8("mid0", 8'h30, 1'b0, 1'b0, 1'b1);
    op8(8'h01, 8'h02);
    rst = 1'b1;
    step();
    chk8("mid1", 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    b8.in_valid = 1'b0;

    // all lanes were just reset together
    for (int k = 0; k < 3; k++) exp[k] = '0;

    for (int t = 0; t < 1000; t++) begin
      for (int k = 0; k < 3; k++) begin
        ra[k] = {$urandom, $urandom} & mask(wid[k]);
        rb[k] = {$urandom, $urandom} & mask(wid[k]);
        rv[k] = ($urandom_range(0, 7) != 0);
      end
      b1.in_valid  = rv[0]; b1.A  = ra[0][0];    b1.B  = rb[0][0];
      b8.in_valid  = rv[1]; b8.A  = ra[1][7:0];  b8.B  = rb[1][7:0];
      b32.in_valid = rv[2]; b32.A = ra[2][31:0]; b32.B = rb[2][31:0];
      step();
      obs[0] = {b1.Ovf, b1.Cout, 64'(b1.Sum)};
      obs[1] = {b8.Ovf, b8.Cout, 64'(b8.Sum)};
      obs[2] = {b32.Ovf, b32.Cout, 64'(b32.Sum)};
      chk("rnd.v1", 66'(b1.out_valid), 66'(rv[0]));
      chk("rnd.v8", 66'(b8.out_valid), 66'(rv[1]));
      chk("rnd.v32", 66'(b32.out_valid), 66'(rv[2]));
      for (int k = 0; k < 3; k++) begin
        if (rv[k]) exp[k] = ref_add(wid[k], ra[k], rb[k]);
        chk($sformatf("rnd.n%0d.t%0d", wid[k], t), obs[k], exp[k]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
